// File: rtl/sprite_line_engine.sv
// sprite_line_engine: per-scanline sprite scanner and pixel mixer.
// During horizontal blanking the attribute table is scanned for sprites on
// the next line. Up to VISIBLE_SPRITES pattern rows are loaded into slots,
// and the slots are shifted out pixel by pixel on the following line.
// Optional feature: define SPRITE_COLLISION_EN to build the sticky collision
// detector; without it, collision is tied to 0.
// Handshake note: both memory ports are plain synchronous reads. The address
// is registered here, and the data is consumed in the state that follows
// the request state.
module sprite_line_engine #(
    parameter int VISIBLE_SPRITES = 4,
    parameter int SPRITE_ATTRS    = 16,
    parameter int SPRITE_ROWS     = 16,
    parameter int BPP             = 2,
    localparam int AW = (SPRITE_ATTRS > 1) ? $clog2(SPRITE_ATTRS) : 1,
    localparam int NW = $clog2(VISIBLE_SPRITES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   hcount,
    input  logic [9:0]    vcount,
    output logic [AW-1:0] attr_addr,
    input  logic [31:0]   attr_data,
    output logic [7:0]    pat_addr,
    input  logic [31:0]   pat_data,
    input  logic          clr_flags,
    output logic [3:0]    pix_color,
    output logic          pix_opaque,
    output logic          overflow,
    output logic          collision,
    output logic [2:0]    o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_A_REQ, S_CHECK, S_P_REQ, S_LOAD, S_WAIT, S_OUTPUT
    } state_t;

    localparam logic [10:0] ROWS_L = 11'(SPRITE_ROWS);

    state_t          r_state;
    logic [AW-1:0]   r_attr_addr;
    logic [7:0]      r_pat_addr;
    logic [9:0]      r_target;
    logic [NW-1:0]   r_nslots;
    logic [9:0]      r_hit_x;
    logic [3:0]      r_hit_pal;
    logic            r_overflow;
    logic [3:0]      r_pix_color;
    logic            r_pix_opaque;
    logic            r_valid [VISIBLE_SPRITES];
    logic [9:0]      r_cnt   [VISIBLE_SPRITES];
    logic [31:0]     r_shift [VISIBLE_SPRITES];
    logic [3:0]      r_pal   [VISIBLE_SPRITES];

    logic [9:0]      w_diff;
    logic            w_hit, w_last, w_full, w_trunc, w_start, w_load, w_ovf_set;
    logic [BPP-1:0]  w_pix [VISIBLE_SPRITES];
    logic [3:0]      w_color;
    logic            w_opaque;

    // Row within the sprite; the mod-1024 wrap lets y near 1023 reach line 0.
    assign w_diff    = r_target - attr_data[9:0];
    assign w_hit     = ({1'b0, w_diff} < ROWS_L);
    assign w_last    = (r_attr_addr == AW'(SPRITE_ATTRS - 1));
    assign w_full    = (r_nslots == NW'(VISIBLE_SPRITES));
    assign w_trunc   = (hcount == 11'd1598);
    assign w_start   = (r_state == S_IDLE) && (hcount == 11'd1280);
    assign w_load    = (r_state == S_LOAD) && !w_trunc;
    assign w_ovf_set = (r_state == S_CHECK) && !w_trunc && w_hit && w_full;

    // Scan/output sequencer; hcount==1598 cuts any scan short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_attr_addr <= '0;
            r_pat_addr  <= '0;
            r_target    <= '0;
            r_nslots    <= '0;
            r_hit_x     <= '0;
            r_hit_pal   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_A_REQ;
                        r_attr_addr <= '0;
                        r_nslots    <= '0;
                        r_target    <= (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
                    end
                end
                S_A_REQ: r_state <= w_trunc ? S_WAIT : S_CHECK;
                S_CHECK: begin
                    if (w_trunc) begin
                        r_state <= S_WAIT;
                    end else if (w_hit) begin
                        if (w_full) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_pat_addr <= attr_data[27:20] + w_diff[7:0];
                            r_hit_x    <= attr_data[19:10];
                            r_hit_pal  <= attr_data[31:28];
                            r_state    <= S_P_REQ;
                        end
                    end else if (w_last) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_attr_addr <= r_attr_addr + AW'(1);
                        r_state     <= S_A_REQ;
                    end
                end
                S_P_REQ: r_state <= w_trunc ? S_WAIT : S_LOAD;
                S_LOAD: begin
                    if (w_trunc) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_nslots <= r_nslots + NW'(1);
                        if (w_last) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_attr_addr <= r_attr_addr + AW'(1);
                            r_state     <= S_A_REQ;
                        end
                    end
                end
                S_WAIT:   if (hcount == 11'd1599) r_state <= S_OUTPUT;
                S_OUTPUT: if (hcount == 11'd1279) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Slot registers: clear at scan start, fill lowest-free, then count down and shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VISIBLE_SPRITES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= '0;
                r_shift[i] <= '0;
                r_pal[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < VISIBLE_SPRITES; i++) begin
                if (w_start) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load && (r_nslots == NW'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_cnt[i]   <= r_hit_x;
                    r_shift[i] <= pat_data;
                    r_pal[i]   <= r_hit_pal;
                end else if ((r_state == S_OUTPUT) && hcount[0]) begin
                    if (r_cnt[i] != 10'd0) r_cnt[i] <= r_cnt[i] - 10'd1;
                    else r_shift[i] <= r_shift[i] << BPP;
                end
            end
        end
    end

    // Current pixel of every slot; unloaded or not-yet-started slots are transparent.
    always_comb begin
        for (int i = 0; i < VISIBLE_SPRITES; i++) begin
            w_pix[i] = (r_valid[i] && (r_cnt[i] == 10'd0)) ? r_shift[i][31 -: BPP] : '0;
        end
    end

    // Priority mix: iterate downward so the lowest opaque slot wins.
    always_comb begin
        w_color  = '0;
        w_opaque = 1'b0;
        for (int i = VISIBLE_SPRITES - 1; i >= 0; i--) begin
            if (w_pix[i] != '0) begin
                w_opaque = 1'b1;
                w_color  = r_pal[i] + 4'(w_pix[i]);
            end
        end
    end

    // Register the mixed pixel once per column (on even hcount).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_color  <= '0;
            r_pix_opaque <= 1'b0;
        end else if (!hcount[0]) begin
            if (r_state == S_OUTPUT) begin
                r_pix_color  <= w_color;
                r_pix_opaque <= w_opaque;
            end else begin
                r_pix_color  <= '0;
                r_pix_opaque <= 1'b0;
            end
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_overflow <= 1'b0;
        else if (w_ovf_set) r_overflow <= 1'b1;
        else if (clr_flags) r_overflow <= 1'b0;
    end

`ifdef SPRITE_COLLISION_EN
    logic w_seen, w_multi, r_collision;

    // Two or more opaque slots on the same pixel.
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < VISIBLE_SPRITES; i++) begin
            if (w_pix[i] != '0) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
            end
        end
    end

    // Sticky collision, sampled once per output column; set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                              r_collision <= 1'b0;
        else if ((r_state == S_OUTPUT) && !hcount[0] && w_multi) r_collision <= 1'b1;
        else if (clr_flags)                                     r_collision <= 1'b0;
    end

    assign collision = r_collision;
`else
    assign collision = 1'b0;
`endif

    assign attr_addr   = r_attr_addr;
    assign pat_addr    = r_pat_addr;
    assign pix_color   = r_pix_color;
    assign pix_opaque  = r_pix_opaque;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: drives raster timing and attribute/pattern memories.
// Expected pixels and flags are computed by a line-level reference model
// and compared by an independent monitor.
module tb_sprite_line_engine;
    localparam int VISIBLE_SPRITES = 4;
    localparam int SPRITE_ATTRS    = 16;
    localparam int SPRITE_ROWS     = 16;
    localparam int BPP             = 2;
    localparam int PW              = 32 / BPP;
    localparam logic [31:0] PMASK  = 32'((1 << BPP) - 1);
    localparam int AW              = $clog2(SPRITE_ATTRS);

    logic          clk, reset, clr_flags;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic [AW-1:0] attr_addr;
    logic [31:0]   attr_data, pat_data;
    logic [7:0]    pat_addr;
    logic [3:0]    pix_color;
    logic          pix_opaque, overflow, collision;
    logic [2:0]    dbg_state;

    sprite_line_engine #(
        .VISIBLE_SPRITES(VISIBLE_SPRITES), .SPRITE_ATTRS(SPRITE_ATTRS),
        .SPRITE_ROWS(SPRITE_ROWS), .BPP(BPP)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .attr_addr(attr_addr), .attr_data(attr_data),
        .pat_addr(pat_addr), .pat_data(pat_data), .clr_flags(clr_flags),
        .pix_color(pix_color), .pix_opaque(pix_opaque),
        .overflow(overflow), .collision(collision), .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- synchronous-read memories ----------------
    logic [31:0] attr_mem [SPRITE_ATTRS];
    logic [31:0] pat_mem  [256];

    always @(posedge clk) begin
        attr_data <= attr_mem[attr_addr];
        pat_data  <= pat_mem[pat_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [4:0] exp_q [$];
    logic [1:0] flag_q [$];
    logic [3:0] exp_color [640];
    logic       exp_opq   [640];
    logic       line_ovf, line_col, exp_ovf, exp_col, mon_en;
    int         n_total, n_pass, cur_line;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s line=%0d hcount=%0d got=%0h exp=%0h", name, cur_line, hcount, got, exp);
    endtask

    function automatic logic [31:0] mk_attr(input int y, input int x, input int base, input int pal);
        logic [31:0] r;
        r[9:0]   = y[9:0];
        r[19:10] = x[9:0];
        r[27:20] = base[7:0];
        r[31:28] = pal[3:0];
        return r;
    endfunction

    task automatic clear_attrs();
        for (int i = 0; i < SPRITE_ATTRS; i++) attr_mem[i] = mk_attr(600, 0, 0, 0);
    endtask

    // Reference model: what line L should look like, from the attribute rules.
    task automatic build_line(input int L);
        int hits[$];
        int y, d, x, k, row, pv;
        bit seen;
        logic [31:0] a, p;
        hits = {};
        line_ovf = 1'b0;
        line_col = 1'b0;
        for (int i = 0; i < SPRITE_ATTRS; i++) begin
            a = attr_mem[i];
            y = int'(a[9:0]);
            d = (L - y + 1024) % 1024;
            if (d < SPRITE_ROWS) begin
                if (hits.size() < VISIBLE_SPRITES) hits.push_back(i);
                else begin
                    line_ovf = 1'b1;
                    break;
                end
            end
        end
        for (int c = 0; c < 640; c++) begin
            exp_color[c] = 4'd0;
            exp_opq[c]   = 1'b0;
            seen         = 1'b0;
            foreach (hits[j]) begin
                a = attr_mem[hits[j]];
                x = int'(a[19:10]);
                k = c - x;
                if (k >= 0 && k < PW) begin
                    row = (L - int'(a[9:0]) + 1024) % 1024;
                    p   = pat_mem[(int'(a[27:20]) + row) % 256];
                    pv  = int'((p >> (32 - BPP * (k + 1))) & PMASK);
                    if (pv != 0) begin
                        if (seen) line_col = 1'b1;
                        else begin
                            exp_opq[c]   = 1'b1;
                            exp_color[c] = 4'((int'(a[31:28]) + pv) % 16);
                        end
                        seen = 1'b1;
                    end
                end
            end
        end
    endtask

    // Driver: scan period of the previous line, then the rendered line L.
    task automatic render_line(input int L, input int rst_at, input bit do_clr);
        int prev;
        prev = (L == 0) ? 524 : L - 1;
        build_line(L);
        @(negedge clk);
        hcount = 11'd1270; vcount = 10'(prev); cur_line = L;
        for (int h = 1271; h < 1600; h++) begin
            @(negedge clk);
            hcount = 11'(h);
            clr_flags = 1'b0;
            if (do_clr && h == 1271) begin
                check("overflow_pre_clr", 32'(overflow), 32'(exp_ovf));
                check("collision_pre_clr", 32'(collision), 32'(exp_col));
            end
            if (do_clr && h == 1272) begin
                clr_flags = 1'b1;
                exp_ovf = 1'b0;
                exp_col = 1'b0;
            end
            if (do_clr && h == 1275) begin
                check("overflow_post_clr", 32'(overflow), 32'(exp_ovf));
                check("collision_post_clr", 32'(collision), 32'(exp_col));
            end
            if (h == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_pix_color", 32'(pix_color), 0);
                check("rst_pix_opaque", 32'(pix_opaque), 0);
                check("rst_overflow", 32'(overflow), 0);
                check("rst_collision", 32'(collision), 0);
                check("rst_attr_addr", 32'(attr_addr), 0);
                check("rst_pat_addr", 32'(pat_addr), 0);
                check("rst_state", 32'(dbg_state), 0);
                exp_ovf = 1'b0;
                exp_col = 1'b0;
            end
            if (rst_at != 0 && h == rst_at + 3) reset = 1'b0;
        end
        if (rst_at != 0) begin
            for (int c = 0; c < 640; c++) begin
                exp_color[c] = 4'd0;
                exp_opq[c]   = 1'b0;
            end
            line_ovf = 1'b0;
            line_col = 1'b0;
        end
        exp_ovf = exp_ovf | line_ovf;
`ifdef SPRITE_COLLISION_EN
        exp_col = exp_col | line_col;
`endif
        flag_q.push_back({exp_ovf, exp_col});
        for (int h = 0; h < 1280; h++) begin
            @(negedge clk);
            hcount = 11'(h); vcount = 10'(L); mon_en = 1'b1;
            if (h % 2 == 0) exp_q.push_back({exp_opq[h / 2], exp_color[h / 2]});
        end
        @(negedge clk);
        mon_en = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [4:0] e;
        logic [1:0] f;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && !hcount[0] && hcount < 11'd1280) begin
                if (exp_q.size() == 0) check("pix_queue_empty", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check($sformatf("pix_col%0d", hcount / 2), 32'({pix_opaque, pix_color}), 32'(e));
                end
                if (hcount == 11'd1278) begin
                    if (flag_q.size() == 0) check("flag_queue_empty", 1, 0);
                    else begin
                        f = flag_q.pop_front();
                        check("overflow", 32'(overflow), 32'(f[1]));
                        check("collision", 32'(collision), 32'(f[0]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int L, y, pv;
        logic [31:0] w;
        n_total = 0; n_pass = 0; cur_line = 0;
        reset = 1'b1; clr_flags = 1'b0; hcount = 11'd0; vcount = 10'd0;
        mon_en = 1'b0; exp_ovf = 1'b0; exp_col = 1'b0;
        for (int i = 0; i < 256; i++) begin
            w = 32'd0;
            for (int k = 0; k < PW; k++) begin
                pv = $urandom_range(0, 5);
                if (pv > 3) pv = 0;
                w = (w << BPP) | 32'(pv);
            end
            pat_mem[i] = w;
        end
        clear_attrs();
        repeat (3) @(negedge clk);
        check("init_pix_color", 32'(pix_color), 0);
        check("init_pix_opaque", 32'(pix_opaque), 0);
        check("init_overflow", 32'(overflow), 0);
        check("init_collision", 32'(collision), 0);
        check("init_attr_addr", 32'(attr_addr), 0);
        check("init_pat_addr", 32'(pat_addr), 0);
        check("init_state", 32'(dbg_state), 0);
        reset = 1'b0;

        // Single sprite: column 100 shows palette 4 + pixel 1.
        clear_attrs();
        attr_mem[0] = mk_attr(10, 100, 8'h00, 4);
        pat_mem[0]  = 32'h4000_0000;
        render_line(10, 0, 0);

        // Five sprites on one line: only the first four drawn, overflow sticky.
        clear_attrs();
        for (int i = 0; i < 5; i++) begin
            attr_mem[i] = mk_attr(20, 10 + 40 * i, 16 * (i + 3), i);
            pat_mem[16 * (i + 3)] = 32'hFFFF_FFFF;
        end
        render_line(20, 0, 0);
        render_line(21, 0, 1);

        // Reset in the middle of a scan: next line blank, the one after normal.
        clear_attrs();
        attr_mem[0] = mk_attr(40, 60, 8'h20, 5);
        attr_mem[3] = mk_attr(38, 90, 8'h24, 2);
        render_line(41, 1300, 0);
        render_line(42, 0, 0);

        // Two sprites at the same x: attr0 wins, collision per build option.
        clear_attrs();
        attr_mem[0] = mk_attr(30, 50, 8'h50, 1);
        attr_mem[1] = mk_attr(30, 50, 8'h60, 7);
        pat_mem[8'h50] = 32'hC000_0000;
        pat_mem[8'h60] = 32'h4000_0000;
        render_line(30, 0, 1);

        // Vertical wrap: y=1020 shows on lines 0..11, y=470 never wraps.
        clear_attrs();
        attr_mem[0] = mk_attr(1020, 200, 8'h10, 2);
        attr_mem[1] = mk_attr(470, 300, 8'h40, 6);
        for (int r = 0; r < SPRITE_ROWS; r++) begin
            pat_mem[8'h10 + r] = pat_mem[8'h10 + r] | 32'h4000_0000;
            pat_mem[8'h40 + r] = pat_mem[8'h40 + r] | 32'h8000_0000;
        end
        render_line(0, 0, 1);
        render_line(5, 0, 0);
        render_line(11, 0, 0);
        render_line(12, 0, 0);
        render_line(470, 0, 0);
        render_line(475, 0, 0);

        // Right-edge clipping with no wrap to the left edge.
        clear_attrs();
        attr_mem[0] = mk_attr(100, 632, 8'h80, 0);
        pat_mem[8'h80] = 32'hFFFF_FFFF;
        render_line(100, 0, 1);

        // Randomised attribute tables.
        for (int it = 0; it < 8; it++) begin
            L = $urandom_range(1, 523);
            for (int i = 0; i < SPRITE_ATTRS; i++) begin
                if ($urandom_range(0, 2) == 0) y = (L + 1024 + 3 - $urandom_range(0, SPRITE_ROWS + 6)) % 1024;
                else y = 600;
                attr_mem[i] = mk_attr(y, $urandom_range(0, 660), $urandom_range(0, 255), $urandom_range(0, 15));
            end
            render_line(L, 0, 1);
        end

        repeat (5) @(negedge clk);
        check("pix_queue_drained", 32'(exp_q.size()), 0);
        check("flag_queue_drained", 32'(flag_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sprite_line_engine.md
SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

Interface
REQ-001 SHALL have parameter VISIBLE_SPRITES, default 4: sprite slots per scanline.
REQ-002 SHALL have parameter SPRITE_ATTRS, default 16: attribute entries scanned per line (power of two, max 64).
REQ-003 SHALL have parameter SPRITE_ROWS, default 16: sprite height in lines.
REQ-004 SHALL have parameter BPP, default 2: bits per pixel (1, 2 or 4); sprite width = 32/BPP pixels.
REQ-005 SHALL have port clk, input, 1: system clock (50 MHz).
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port hcount, input, 11: horizontal count 0..1599; hcount[10:1] is pixel column.
REQ-008 SHALL have port vcount, input, 10: line count 0..524.
REQ-009 SHALL have port attr_addr, output, log2(SPRITE_ATTRS): attribute read address.
REQ-010 SHALL have port attr_data, input, 32: attribute word; [9:0] y, [19:10] x, [27:20] pattern base, [31:28] palette base.
REQ-011 SHALL have port pat_addr, output, 8: pattern row read address.
REQ-012 SHALL have port pat_data, input, 32: pattern row, leftmost pixel in [31:32-BPP].
REQ-013 SHALL have port clr_flags, input, 1: synchronous clear of sticky flags.
REQ-014 SHALL have port pix_color, output, 4: colour-table index for current pixel.
REQ-015 SHALL have port pix_opaque, output, 1: a sprite pixel is present.
REQ-016 SHALL have port overflow, output, 1: sticky; more sprites matched than slots.
REQ-017 SHALL have port collision, output, 1: sticky; two opaque sprite pixels coincided.

Function
REQ-018 SHALL treat both memory ports as synchronous reads: data valid the cycle after the address is driven.
REQ-019 SHALL use the FSM IDLE, A_REQ, CHECK, P_REQ, LOAD, WAIT, OUTPUT; leave IDLE for A_REQ at hcount==1280 with attr_addr=0, target line T = (vcount==524) ? 0 : vcount+1.
REQ-020 In CHECK, match = (T - y) mod 1024 < SPRITE_ROWS; a miss SHALL advance attr_addr and return to A_REQ.
REQ-021 A hit SHALL drive pat_addr = (pattern base + T - y) mod 256 (P_REQ), and in LOAD latch x, palette and pat_data into the lowest free slot.
REQ-022 A hit with all slots full SHALL set overflow and end the scan (WAIT).
REQ-023 The scan SHALL enter WAIT after entry SPRITE_ATTRS-1 is processed, or immediately at hcount==1598 (truncating); a truncated slot load SHALL be discarded.
REQ-024 WAIT SHALL enter OUTPUT at hcount==1599; OUTPUT SHALL return to IDLE at hcount==1279.
REQ-025 Per slot, a 10-bit down counter loaded with x SHALL decrement once per pixel (on hcount[0]==1); at zero, the slot shifter SHALL emit BPP bits per pixel for 32/BPP pixels, then zeros.
REQ-026 Slot pixel value 0 SHALL be transparent; lowest-numbered opaque slot wins.
REQ-027 pix_color SHALL be (palette base + pixel value) mod 16, else 0; pix_opaque=1 iff a slot is opaque; both registered, presenting column c during hcount 2c+1 and 2c+2.
REQ-028 Unloaded slots SHALL output transparent; all slots SHALL clear on entry to A_REQ.
REQ-029 clr_flags SHALL clear overflow/collision; a simultaneous set event SHALL win.
REQ-030 Sprites with x+width > 639 SHALL be clipped at column 639 without wrapping.

Reset
REQ-031 reset SHALL force IDLE, clear all slots, drive attr_addr=0, pat_addr=0, pix_color=0, pix_opaque=0, overflow=0, collision=0, at any time including mid-scan or mid-output.
REQ-032 After reset release, the first scan SHALL start at the next hcount==1280.

Configuration
REQ-033 With SPRITE_COLLISION_EN defined, collision SHALL be set when two or more slots are opaque in the same OUTPUT pixel.
REQ-034 Without SPRITE_COLLISION_EN, collision SHALL be constant 0 and no comparison logic built.

Verification
REQ-035 Attr0 = y 10, x 100, base 0x00, palette 4; pattern row 0 = 0x40000000; vcount 9 -> line 10 column 100 pix_color 5, pix_opaque 1; columns 99/101 transparent.
REQ-036 Five sprites all y 20, VISIBLE_SPRITES 4 -> line 20 shows attrs 0-3 only, overflow=1 until clr_flags pulse.
REQ-037 Attr0 and attr1 both x 50, opaque at column 50 -> pix_color from attr0; collision=1 with SPRITE_COLLISION_EN, 0 without.
REQ-038 y=1020, SPRITE_ROWS 16 -> sprite rows 4..15 drawn on lines 0..11 (mod-1024 match); y=470 -> no wrap onto lines 0..5.
REQ-039 Assert reset at hcount 1300 mid-scan -> all outputs 0 immediately; line after release renders only from scan at next hcount 1280.
